// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared state encoding and one-hot phase constants for phase_seq_ctrl
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] PHASE_IDX0 = 4'b1000;
    localparam logic [3:0] PHASE_IDX1 = 4'b0100;
    localparam logic [3:0] PHASE_IDX2 = 4'b0010;
    localparam logic [3:0] PHASE_IDX3 = 4'b0001;

    function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return PHASE_IDX0;
            2'd1:    return PHASE_IDX1;
            2'd2:    return PHASE_IDX2;
            default: return PHASE_IDX3;
        endcase
    endfunction

endpackage

// File: rtl/phase_tick_gen.sv
// rtl/phase_tick_gen.sv - step-rate divider, one tick every div+1 enabled cycles
module phase_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = enable && (r_cnt == div);

    // Restarting on every tick keeps the counter from ever wrapping past div.
    always_ff @(posedge clk) begin
        if (clr || load) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/phase_seq_ctrl.sv
// rtl/phase_seq_ctrl.sv - 4-phase step sequencer with command handshake; PHASE_HOLD_EN holds phase outside RUN
module phase_seq_ctrl
    import phase_seq_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [3:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             step_pulse
);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_index;
    logic [CNT_W-1:0] r_remaining;
    logic [DIV_W-1:0] r_div;
    logic             r_dir;
    logic             r_step_pulse;
    logic             w_accept;
    logic             w_step;
    logic             w_tick;
    logic             w_run;

    assign w_run = (r_state == ST_RUN);

    phase_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .clr    (clr),
        .load   (w_accept),
        .enable (w_run),
        .div    (r_div),
        .tick   (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // abort wins over a coincident tick: no step is taken.
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick) begin
                    w_step = 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_IDLE;
            r_index      <= 2'd0;
            r_remaining  <= '0;
            r_div        <= '0;
            r_dir        <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_step_pulse <= w_step;
            if (w_accept) begin
                r_dir       <= cmd_dir;
                r_div       <= cmd_div;
                r_remaining <= cmd_steps;
            end
            if (w_step) begin
                r_index <= r_dir ? r_index - 2'd1 : r_index + 2'd1;
                if (r_remaining != '0) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
            end
        end
    end

`ifdef PHASE_HOLD_EN
    // Position is only meaningful once a command has run since the last clear.
    logic r_started;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_started <= 1'b0;
        end else if (w_accept) begin
            r_started <= 1'b1;
        end
    end

    always_comb begin
        phase = 4'b0000;
        if (w_run || r_started) begin
            phase = phase_onehot(r_index);
        end
    end
`else
    always_comb begin
        phase = 4'b0000;
        if (w_run) begin
            phase = phase_onehot(r_index);
        end
    end
`endif

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// tb/tb_phase_seq_ctrl.sv - self-checking bench for phase_seq_ctrl (honours PHASE_HOLD_EN)
module tb_phase_seq_ctrl;

    logic        clk;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [7:0]  cmd_div;
    logic        abort;
    logic [3:0]  phase;
    logic        busy;
    logic        done;
    logic        step_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_index   = 0;
    bit m_started = 0;

    phase_seq_ctrl #(.CNT_W(16), .DIV_W(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       valid;
        logic       dir;
        logic [15:0] steps;
        logic [7:0] div;
        logic       abort;
        logic [7:0] exp;
        logic [3:0] hold_phase;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] top;
        top = 4'b1000;
        return top >> (idx % 4);
    endfunction

    function automatic int idx_after(input int start, input bit dir, input int k);
        return (((start + (dir ? -k : k)) % 4) + 4) % 4;
    endfunction

    function automatic logic [3:0] outside_phase(input int idx, input bit started);
`ifdef PHASE_HOLD_EN
        return started ? onehot(idx) : 4'b0000;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic [7:0] observed();
        return {phase, step_pulse, done, busy, cmd_ready};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {phase,sp,done,busy,ready}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        m_index = 0;
        m_started = 0;
    endtask

    // Offers one command from IDLE and checks every cycle until IDLE returns.
    task automatic run_cmd(input int n, input int d, input bit dir, input int abort_at,
                           input string tag, output int busy_cycles);
        int   total;
        int   start;
        int   done_steps;
        int   abort_steps;
        bit   aborted;
        logic [7:0] exp;
        start = m_index;
        total = n * (d + 1);
        aborted = 0;
        abort_steps = 0;
        busy_cycles = 0;
        cmd_valid = 1'b1; cmd_steps = 16'(n); cmd_div = 8'(d); cmd_dir = dir;
        abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0;
        m_started = 1;
        for (int c = 0; c <= total + 1; c++) begin
            done_steps = c / (d + 1);
            if (aborted) begin
                m_index = idx_after(start, dir, abort_steps);
                exp = {outside_phase(m_index, 1'b1), 4'b0001};
                check({tag, "_abort_idle"}, observed(), exp);
                break;
            end else if (c == total + 1) begin
                m_index = idx_after(start, dir, n);
                exp = {outside_phase(m_index, 1'b1), 4'b0001};
                check({tag, "_idle"}, observed(), exp);
            end else if (c == total) begin
                exp = {outside_phase(idx_after(start, dir, n), 1'b1), (n > 0), 3'b110};
                check({tag, "_done"}, observed(), exp);
            end else begin
                exp = {onehot(idx_after(start, dir, done_steps)),
                       (c > 0 && (c % (d + 1)) == 0), 3'b010};
                check({tag, "_run"}, observed(), exp);
            end
            if (observed() & 8'h02) busy_cycles++;
            if (c == abort_at) begin
                abort = 1'b1;
                aborted = 1;
                abort_steps = done_steps;
            end
            if (c <= total) begin
                @(posedge clk); #1;
                abort = 1'b0;
            end
        end
    endtask

    initial begin
        int bc;
        int n, d, ab;
        bit dir;
        clr = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_div = '0; abort = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 8'b0000_0001, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'd0, 8'd5, 1'b1, 8'b0000_0110, 4'b1000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 8'b0000_0001, 4'b1000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'd2, 8'd0, 1'b0, 8'b1000_0010, 4'b1000};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'd2, 8'd0, 1'b0, 8'b0001_1010, 4'b0001};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'd2, 8'd0, 1'b0, 8'b0000_1110, 4'b0010};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'd2, 8'd0, 1'b0, 8'b0000_0001, 4'b0010};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'd2, 8'd0, 1'b0, 8'b0010_0010, 4'b0010};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1, 8'b0000_0001, 4'b0010};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'd1, 8'd0, 1'b0, 8'b0000_0001, 4'b0000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'd1, 8'd0, 1'b0, 8'b1000_0010, 4'b1000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 8'b0000_1110, 4'b0100};

        for (int i = 0; i < 12; i++) begin
            logic [7:0] exp;
            clr = tbl[i].clr; cmd_valid = tbl[i].valid; cmd_dir = tbl[i].dir;
            cmd_steps = tbl[i].steps; cmd_div = tbl[i].div; abort = tbl[i].abort;
            @(posedge clk); #1;
            exp = tbl[i].exp;
`ifdef PHASE_HOLD_EN
            exp[7:4] = tbl[i].hold_phase;
`endif
            check($sformatf("tbl_row%0d", i), observed(), exp);
        end
        cmd_valid = 1'b0; abort = 1'b0;

        do_clr();
        run_cmd(6, 0, 1'b0, -1, "fwd6_div0", bc);

        do_clr();
        run_cmd(5, 3, 1'b1, -1, "rev5_div3", bc);
        n_cmp++;
        if (bc != 21) begin
            n_fail++;
            $display("FAIL rev5_div3_busy_len: got %0d busy cycles, expected 21", bc);
        end

        run_cmd(0, 2, 1'b0, -1, "zero_steps", bc);

        do_clr();
        run_cmd(10, 2, 1'b0, 9, "abort_3rd", bc);
`ifdef PHASE_HOLD_EN
        check("abort_3rd_hold", observed(), 8'b0001_0001);
`else
        check("abort_3rd_hold", observed(), 8'b0000_0001);
`endif

        // clr in the middle of a run while a new command is already being offered.
        do_clr();
        cmd_valid = 1'b1; cmd_steps = 16'd8; cmd_div = 8'd1; cmd_dir = 1'b0;
        @(posedge clk); #1;
        cmd_steps = 16'd3; cmd_div = 8'd0; cmd_dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("clr_pre_running", observed() & 8'h02, 8'h02);
        clr = 1'b1;
        @(posedge clk); #1;
        check("clr_mid_run_1", observed(), 8'b0000_0001);
        @(posedge clk); #1;
        check("clr_mid_run_2", observed(), 8'b0000_0001);
        clr = 1'b0;
        @(posedge clk); #1;
        check("clr_release_accept", observed(), 8'b1000_0010);
        cmd_valid = 1'b0;
        do_clr();

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 6);
            d = $urandom_range(0, 3);
            dir = 1'($urandom_range(0, 1));
            ab = -1;
            if (n > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(0, n * (d + 1) - 1);
            run_cmd(n, d, dir, ab, $sformatf("rnd%0d", r), bc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
